// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive frame stage and the transmitter.
// Pure types/constants: no latency, no flow control.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rs232_rx synchronizer with falling-edge detect on the two oldest flops.
// Latency SYNC_STAGES-1 clocks to rx_s/fall; no backpressure (free-running).
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;

  // r_sync[SYNC_STAGES-1] is the oldest sample.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{UART_IDLE_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end
  end

  assign o_rx_s = r_sync[SYNC_STAGES-2];
  assign o_fall = !r_sync[SYNC_STAGES-2] && r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 receive framer: start revalidation, framing error pulse, break hold-off.
// rx_int falls one clock after the stop-bit clk_bps; paced only by clk_bps.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter bit START_CHECK = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rs232_rx,
  input  logic                      clk_bps,
  output logic                      bps_start,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_int,
  output logic                      frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  logic                      w_fall;
  logic                      w_tick;
  rx_state_t                 r_state;
  logic [3:0]                r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_rx_data;
  logic                      r_bps_start;
  logic                      r_rx_int;
  logic                      r_frame_err;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_rx   (rs232_rx),
    .o_rx_s (w_rx_s),
    .o_fall (w_fall)
  );

  // A stray clk_bps while we are not requesting the baud generator is ignored.
  assign w_tick = clk_bps && r_bps_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_bps_start <= 1'b0;
      r_rx_int    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state     <= START;
            r_bps_start <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            if (!w_rx_s || !START_CHECK) begin
              r_state   <= DATA;
              r_rx_int  <= 1'b1;
              r_bit_cnt <= 4'd0;
            end else begin
              r_state     <= IDLE;
              r_bps_start <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= STOP;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_rx_data   <= r_shift;
            r_rx_int    <= 1'b0;
            r_bps_start <= 1'b0;
            if (w_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end
        end
        BREAK: begin
          // Held-low line must return high before a new start can be seen.
          if (w_rx_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bps_start = r_bps_start;
  assign rx_data   = r_rx_data;
  assign rx_int    = r_rx_int;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three instances (SYNC_STAGES 2/3/4) share one line.
// A queue of expected bytes is compared with bytes captured at rx_int falls.
module tb_uart_rx_frame;

  localparam int BIT_CLKS = 16;
  localparam int NI       = 3;

  logic          clk;
  logic          rst_n;
  logic          rs232_rx;
  logic [NI-1:0] clk_bps_v;
  logic [NI-1:0] bps_v;
  logic [NI-1:0] int_v;
  logic [NI-1:0] fe_v;
  logic [7:0]    data_v [NI];

  int checks   = 0;
  int failures = 0;

  uart_rx_frame #(.SYNC_STAGES(2), .START_CHECK(1'b1)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx), .clk_bps(clk_bps_v[0]),
    .bps_start(bps_v[0]), .rx_data(data_v[0]), .rx_int(int_v[0]), .frame_err(fe_v[0]));
  uart_rx_frame #(.SYNC_STAGES(3), .START_CHECK(1'b1)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx), .clk_bps(clk_bps_v[1]),
    .bps_start(bps_v[1]), .rx_data(data_v[1]), .rx_int(int_v[1]), .frame_err(fe_v[1]));
  uart_rx_frame #(.SYNC_STAGES(4), .START_CHECK(1'b1)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx), .clk_bps(clk_bps_v[2]),
    .bps_start(bps_v[2]), .rx_data(data_v[2]), .rx_int(int_v[2]), .frame_err(fe_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud generator model: first pulse half a bit after bps_start, then every bit.
  int bcnt [NI];
  initial begin
    clk_bps_v = '0;
    for (int i = 0; i < NI; i++) bcnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (!bps_v[i]) begin
          bcnt[i]      = 0;
          clk_bps_v[i] = 1'b0;
        end else begin
          bcnt[i]      = bcnt[i] + 1;
          clk_bps_v[i] = (bcnt[i] % BIT_CLKS) == (BIT_CLKS / 2);
        end
      end
    end
  end

  // Observation: bytes delivered at each rx_int fall, plus event counters.
  logic [7:0] got [NI][64];
  int         got_n [NI];
  int         rises [NI];
  int         fe_cnt [NI];
  int         fe_wide [NI];
  int         data_glitch [NI];
  logic       prev_int [NI];
  logic       prev_fe [NI];
  logic [7:0] prev_data [NI];
  bit         rst_window = 1'b0;

  initial begin
    for (int i = 0; i < NI; i++) begin
      got_n[i] = 0; rises[i] = 0; fe_cnt[i] = 0; fe_wide[i] = 0; data_glitch[i] = 0;
      prev_int[i] = 1'b0; prev_fe[i] = 1'b0; prev_data[i] = 8'h00;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (prev_int[i] && !int_v[i] && !rst_window && got_n[i] < 64) begin
        got[i][got_n[i]] = data_v[i];
        got_n[i]++;
      end
      if (!prev_int[i] && int_v[i]) rises[i]++;
      if (fe_v[i] === 1'b1) begin
        fe_cnt[i]++;
        if (prev_fe[i]) fe_wide[i]++;
      end
      if (data_v[i] !== prev_data[i] && !(prev_int[i] && !int_v[i]) && !rst_window)
        data_glitch[i]++;
      prev_int[i]  = int_v[i];
      prev_fe[i]   = fe_v[i];
      prev_data[i] = data_v[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  int         dly [NI];

  // Drives one frame at negedges. measure: record bps_start delay, counted in
  // clock cycles inclusive of the cycle in which the line falls.
  // rst_bit >= 0 pulses rst_n for one clock in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_val,
                            input bit measure, input int rst_bit);
    for (int i = 0; i < NI; i++) dly[i] = 0;
    rs232_rx = 1'b0;
    for (int j = 1; j <= BIT_CLKS; j++) begin
      @(negedge clk);
      if (measure)
        for (int i = 0; i < NI; i++)
          if (bps_v[i] && dly[i] == 0) dly[i] = j + 1;
    end
    for (int k = 0; k < 8; k++) begin
      rs232_rx = b[k];
      if (k == rst_bit) begin
        repeat (7) @(negedge clk);
        rst_window = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("midrst_rx_int[%0d]", i), int_v[i], 1'b0);
          chk($sformatf("midrst_bps[%0d]", i), bps_v[i], 1'b0);
          chk($sformatf("midrst_data[%0d]", i), data_v[i], 8'h00);
        end
        repeat (BIT_CLKS - 9) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    rs232_rx = stop_val;
    repeat (BIT_CLKS) @(negedge clk);
    rs232_rx = 1'b1;
  endtask

  task automatic check_frames(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_count[%0d]", tag, i), got_n[i], exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_n[i]; k++)
        chk($sformatf("%s_byte%0d[%0d]", tag, k, i), got[i][k], exp_q[k]);
    end
  endtask

  int  rises_before [NI];
  bit  bps_seen [NI];
  logic [7:0] rb;

  initial begin
    rst_n    = 1'b0;
    rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_bps[%0d]", i), bps_v[i], 1'b0);
      chk($sformatf("reset_rx_int[%0d]", i), int_v[i], 1'b0);
      chk($sformatf("reset_rx_data[%0d]", i), data_v[i], 8'h00);
      chk($sformatf("reset_frame_err[%0d]", i), fe_v[i], 1'b0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte, with bps_start rise delay per synchronizer depth.
    send_frame(8'h55, 1'b1, 1'b1, -1);
    exp_q.push_back(8'h55);
    chk("delay_s2", dly[0], 3);
    chk("delay_s3", dly[1], 4);
    chk("delay_s4", dly[2], 5);
    repeat (8) @(negedge clk);
    check_frames("b55");

    // Back-to-back frames with no idle beyond the stop bit.
    send_frame(8'hA3, 1'b1, 1'b0, -1);
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    repeat (8) @(negedge clk);
    check_frames("b2b");

    // Three-clock glitch: baud request pulses, no frame is started.
    for (int i = 0; i < NI; i++) begin
      rises_before[i] = rises[i];
      bps_seen[i] = 1'b0;
    end
    rs232_rx = 1'b0;
    repeat (3) @(negedge clk);
    rs232_rx = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) if (bps_v[i]) bps_seen[i] = 1'b1;
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("glitch_bps_pulsed[%0d]", i), bps_seen[i], 1'b1);
      chk($sformatf("glitch_bps_low[%0d]", i), bps_v[i], 1'b0);
      chk($sformatf("glitch_no_rise[%0d]", i), rises[i], rises_before[i]);
    end
    check_frames("glitch");

    // Framing error followed by a long break, then a clean frame.
    for (int i = 0; i < NI; i++) rises_before[i] = rises[i];
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    exp_q.push_back(8'h3C);
    rs232_rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("break_bps_low[%0d]", i), bps_v[i], 1'b0);
      chk($sformatf("break_one_rise[%0d]", i), rises[i], rises_before[i] + 1);
      chk($sformatf("break_fe_count[%0d]", i), fe_cnt[i], 1);
    end
    repeat (19 * BIT_CLKS) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    exp_q.push_back(8'h81);
    repeat (8) @(negedge clk);
    check_frames("break");

    // Reset in the middle of a frame, then a normal frame.
    send_frame(8'hFF, 1'b1, 1'b0, 4);
    repeat (4) @(negedge clk);
    rst_window = 1'b0;
    for (int i = 0; i < NI; i++) prev_data[i] = data_v[i];
    send_frame(8'h12, 1'b1, 1'b0, -1);
    exp_q.push_back(8'h12);
    repeat (8) @(negedge clk);
    check_frames("midrst");

    // Random bytes with random idle gaps.
    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, 1'b0, -1);
      exp_q.push_back(rb);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check_frames("rand");

    // Whole-run properties; the reset-aborted frame also raised rx_int once.
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("total_rises[%0d]", i), rises[i], exp_q.size() + 1);
      chk($sformatf("fe_total[%0d]", i), fe_cnt[i], 1);
      chk($sformatf("fe_width[%0d]", i), fe_wide[i], 0);
      chk($sformatf("data_stable[%0d]", i), data_glitch[i], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive stage directly upstream of the UART transmitter. Recovers 8N1 frames from the rs232_rx line and produces rx_data and rx_int for the transmitter.
- Byte-complete is signalled by a falling edge on rx_int, which is the transmitter's trigger.
- Shares the baud generator: asserts bps_start and consumes clk_bps, a 1-cycle pulse at each bit centre.
- Adds start-bit revalidation, a framing-error flag and break handling.

Parameters:
SYNC_STAGES, 3, number of flops on rs232_rx before use; legal 2..4; the edge detector uses the last two.
START_CHECK, 1, 1 = resample the start bit at its centre and reject glitches; 0 = accept every falling edge.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset; one clock domain, sampled on rising edge of clk
rs232_rx  input  1  asynchronous serial line; idle high
clk_bps  input  1  1-cycle pulse at bit centre; first pulse half a bit after bps_start rises
bps_start  output  1  request to baud generator; high for the whole frame
rx_data  output  8  last received byte, LSB first on the wire
rx_int  output  1  high while a validated frame is in progress; falling edge = rx_data valid
frame_err  output  1  1-cycle pulse when the stop bit samples 0

Behaviour:
- Reset (rst_n=0 at a clk edge): all synchronizer flops=1, state=IDLE, bps_start=0, rx_int=0, rx_data=8'h00, frame_err=0, bit counter=0, shift register=0.
- Reset mid-frame aborts immediately to the above values. No falling edge on rx_int is generated by reset itself, because reset drives rx_int low in the same edge.
- Edge detect: fall = sync[last-1]==0 && sync[last]==1, where sync[last] is the older sample. rx_s = sync[last-1].
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on fall, go to START next cycle and set bps_start=1. Ignore clk_bps.
- START, on clk_bps:
  - rx_s==0 or START_CHECK==0: go to DATA, rx_int<=1, bit counter<=0.
  - rx_s==1 (glitch): go to IDLE, bps_start<=0. rx_int never rose, so the transmitter sees nothing.
- DATA, on clk_bps: shift <= {rx_s, shift[7:1]}; bit counter increments. When the counter reaches 8 (the 8th sample has been taken), go to STOP.
- STOP, on clk_bps:
  - In all cases: rx_data <= shift, rx_int <= 0, bps_start <= 0.
  - rx_s==1: go to IDLE.
  - rx_s==0: frame_err=1 for this cycle only; go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. Edges are ignored while in BREAK, so a held-low line cannot retrigger.
- rx_data changes only in the same cycle rx_int falls and is otherwise stable. The transmitter captures it 1–2 cycles later, so rx_data must stay stable for at least 3 cycles after the fall. Guaranteed, because the next update needs a full frame.
- A fall in the same cycle as the STOP→IDLE transition is ignored. The next fall is detected normally; this costs at most 1 cycle of the next start bit.
- Between clk_bps pulses every state holds. clk_bps arriving with bps_start=0 has no effect.
- Latency: rx_int falls in the cycle after the stop-bit clk_bps pulse (registered). bps_start rises SYNC_STAGES+1 cycles after the line falls.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}
  - UART_DATA_BITS = 8
  - UART_IDLE_LEVEL = 1'b1
  - The transmitter also uses UART_DATA_BITS and UART_IDLE_LEVEL from this package.
- Sub-module uart_rx_sync: parameterised synchronizer plus falling-edge detect; outputs rx_s and fall. Reset value of the flops is 1.

Test Plan:
- Send 0x55 8N1, clk_bps every 16 clk -> bps_start high, rx_int rises after the start-bit sample, then falls; rx_data=0x55 in the fall cycle; frame_err never 1.
- Send back-to-back 0xA3 then 0x0F with no idle gap beyond the stop bit -> two rx_int falling edges; rx_data=0xA3 then 0x0F.
- 3-clk low glitch on idle line, cleared before the first clk_bps -> bps_start pulses then returns 0; rx_int stays 0; state=IDLE.
- Send 0x3C with stop bit 0, line held low 40 bit-times -> rx_data=0x3C, frame_err one 1-cycle pulse, no second frame until the line returns high; then 0x81 is received correctly.
- Assert rst_n=0 for 1 clk during bit 4 of 0xFF -> rx_int, bps_start=0 next edge, rx_data=0x00; the following 0x12 is received correctly.
- SYNC_STAGES=2 and 4 each with 0xC6 -> correct data; bps_start rise delay equals SYNC_STAGES+1 cycles.
